// File: rtl/main_memory_pkg.sv
// -----------------------------------------------------------------------------
// main_memory_pkg
//   Shared definitions for the line-oriented main memory controller:
//     - default parameter values for main_memory_line_ctrl
//     - FSM state enum (IDLE -> WAIT -> RESP -> IDLE)
//     - pattern_line(): the contents returned for a line never written
//       since reset (word k = aligned address + k * bytes-per-word).
// -----------------------------------------------------------------------------
package main_memory_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_WORD_W  = 32;
  localparam int DEF_WORDS   = 4;
  localparam int DEF_DEPTH   = 64;
  localparam int DEF_LATENCY = 3;

  // Widest line pattern_line() can build; callers cast the result down to
  // their own LINE_W. Word width is limited to 64 bits by the address math.
  localparam int PAT_MAX_W = 4096;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Build the default line for an aligned address. Each word is the byte
  // address of that word, truncated to word_w bits. Bounds are elaboration
  // constants at every call site, so the loops unroll into plain adders.
  function automatic logic [PAT_MAX_W-1:0] pattern_line(
    input logic [63:0] aligned_addr,
    input int          words,
    input int          word_w
  );
    logic [PAT_MAX_W-1:0] line;
    logic [63:0]          word_val;
    line = '0;
    for (int k = 0; k < words; k++) begin
      word_val = aligned_addr + 64'(k * (word_w / 8));
      for (int b = 0; b < word_w; b++) begin
        line[k*word_w + b] = word_val[b];
      end
    end
    return line;
  endfunction

endpackage

// File: rtl/mem_line_store.sv
// -----------------------------------------------------------------------------
// mem_line_store
//   DEPTH x LINE_W line storage with one valid bit per line and a pattern
//   fallback for lines not written since reset.
//
//   Ports
//     clk          in   clock
//     rst_n        in   async active-low reset (clears valid bits only)
//     en           in   request accepted this cycle
//     we           in   1 = write line, 0 = read line
//     idx          in   line index
//     aligned_addr in   line-aligned byte address (for the pattern)
//     wdata        in   write line
//     line         out  line captured at the last accepting edge: written
//                       data for a write, stored data for a valid line,
//                       otherwise the address pattern
// -----------------------------------------------------------------------------
module mem_line_store
  import main_memory_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WORD_W = DEF_WORD_W,
  parameter int WORDS  = DEF_WORDS,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int LINE_W = WORDS * WORD_W,
  parameter int IDX    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [IDX-1:0]    idx,
  input  logic [ADDR_W-1:0] aligned_addr,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] line
);

  // Line storage is deliberately not reset so it maps onto block RAM.
  logic [LINE_W-1:0] mem [DEPTH];
  logic [LINE_W-1:0] rd_mem_q;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic              hit_q,   hit_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;

  // Write-first port: a write returns its own data as the acknowledge line,
  // so the response path never needs a separate copy of wdata.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[idx] <= wdata;
      end
      rd_mem_q <= we ? wdata : mem[idx];
    end
  end

  always_comb begin
    valid_d = valid_q;
    hit_d   = hit_q;
    addr_d  = addr_q;
    if (en) begin
      // A write always "hits" so the acknowledge carries the written line.
      hit_d  = we | valid_q[idx];
      addr_d = aligned_addr;
      if (we) begin
        valid_d[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      hit_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      hit_q   <= hit_d;
      addr_q  <= addr_d;
    end
  end

  // All selects are registered at the accepting edge, so this output is
  // stable for as long as the controller holds a response.
  always_comb begin
    line = hit_q ? rd_mem_q
                 : LINE_W'(pattern_line(64'(addr_q), WORDS, WORD_W));
  end

endmodule

// File: rtl/main_memory_line_ctrl.sv
// -----------------------------------------------------------------------------
// main_memory_line_ctrl
//   Single-outstanding-request line memory with fixed access latency.
//   A request is accepted in IDLE; the response appears LATENCY cycles later
//   and is held until resp_ready. Writes are acknowledged with the written
//   line. Lines not written since reset read back an address pattern.
//
//   Ports
//     clk         in   rising-edge clock
//     rst_n       in   async active-low reset
//     req_valid   in   request present
//     req_ready   out  request accepted when req_valid & req_ready
//     req_we      in   1 = line write, 0 = line read
//     req_addr    in   byte address, offset bits ignored
//     req_wdata   in   write line, word 0 in the low WORD_W bits
//     resp_valid  out  response present
//     resp_ready  in   response consumed when resp_valid & resp_ready
//     resp_rdata  out  read line / written line; zero when no response
// -----------------------------------------------------------------------------
module main_memory_line_ctrl
  import main_memory_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int WORD_W  = DEF_WORD_W,
  parameter int WORDS   = DEF_WORDS,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [WORDS*WORD_W-1:0]   req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [WORDS*WORD_W-1:0]   resp_rdata
);

  localparam int LINE_W = WORDS * WORD_W;
  localparam int OFF    = $clog2(LINE_W / 8);
  localparam int IDX    = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(LATENCY) + 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  logic              accept;
  logic [ADDR_W-1:0] aligned_addr;
  logic [IDX-1:0]    line_idx;
  logic [LINE_W-1:0] store_line;

  // Gated with rst_n so nothing can be accepted while reset is held.
  assign req_ready  = rst_n & (state_q == ST_IDLE);
  assign accept     = req_valid & req_ready;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = resp_valid ? store_line : '0;

  // Upper address bits are not compared: addresses that share an index alias.
  always_comb begin
    aligned_addr          = req_addr;
    aligned_addr[OFF-1:0] = '0;
    line_idx              = req_addr[OFF+IDX-1:OFF];
  end

  // Accept at edge T; RESP is entered at edge T+LATENCY-1. The counter is
  // loaded with LATENCY-1 and the WAIT->RESP move happens on the edge where
  // it reads 1, which takes exactly LATENCY-1 WAIT edges.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  mem_line_store #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W),
    .WORDS  (WORDS),
    .DEPTH  (DEPTH),
    .LINE_W (LINE_W),
    .IDX    (IDX)
  ) u_store (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (accept),
    .we           (req_we),
    .idx          (line_idx),
    .aligned_addr (aligned_addr),
    .wdata        (req_wdata),
    .line         (store_line)
  );

endmodule

// File: tb/tb_main_memory_line_ctrl.sv
module tb_main_memory_line_ctrl;

  logic         clk;
  logic         rst_n;
  logic         req_valid, req_ready, req_we;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;
  logic         resp_valid, resp_ready;
  logic [127:0] resp_rdata;

  // Second instance with LATENCY = 1 and resp_ready tied high.
  logic         req_valid_1, req_ready_1, req_we_1;
  logic [31:0]  req_addr_1;
  logic [127:0] req_wdata_1;
  logic         resp_valid_1, resp_ready_1;
  logic [127:0] resp_rdata_1;

  int n_checks = 0;
  int n_fail   = 0;

  main_memory_line_ctrl #(.LATENCY(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata)
  );

  main_memory_line_ctrl #(.LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_1), .req_ready(req_ready_1), .req_we(req_we_1),
    .req_addr(req_addr_1), .req_wdata(req_wdata_1),
    .resp_valid(resp_valid_1), .resp_ready(resp_ready_1), .resp_rdata(resp_rdata_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (64 lines of 16 bytes) ----------------
  logic [127:0] m_mem   [64];
  bit           m_valid [64];

  function automatic logic [127:0] model_line(input logic [31:0] a);
    logic [127:0] l;
    logic [31:0]  base;
    int           i;
    i = int'(a[9:4]);
    if (m_valid[i]) return m_mem[i];
    base = a & 32'hFFFF_FFF0;
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = base + 32'(4 * k);
    return l;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  // One request on the LATENCY=3 instance. lat counts cycles from the
  // accepting edge to the first sample with resp_valid high.
  task automatic transact(input logic we, input logic [31:0] addr,
                          input logic [127:0] wd, input bit complete,
                          input int stall, output logic [127:0] rd,
                          output int lat, output bit timed_out);
    int n;
    timed_out = 1'b0;
    lat = 0;
    rd = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin req_valid = 1'b0; timed_out = 1'b1; return; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (we) begin m_mem[int'(addr[9:4])] = wd; m_valid[int'(addr[9:4])] = 1'b1; end
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 50);
    if (!resp_valid) begin timed_out = 1'b1; return; end
    rd = resp_rdata;
    if (complete) begin
      repeat (stall) @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
    n_checks++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
    n_checks++;
    if (resp_rdata !== 128'h0) begin n_fail++; $display("FAIL reset_resp_rdata got=%h want=0", resp_rdata); end
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got=%b want=1", req_ready); end
    n_checks++;
    if (req_ready_1 !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready_l1 got=%b want=1", req_ready_1); end
    $display("test_reset: done");
  endtask

  task automatic test_read_pattern();
    logic [127:0] rd; int lat; bit to;
    transact(1'b0, 32'h0000_1234, '0, 1'b1, 0, rd, lat, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL pattern_timeout got=timeout want=response"); end
    n_checks++;
    if (lat != 3) begin n_fail++; $display("FAIL pattern_latency got=%0d want=3", lat); end
    n_checks++;
    if (rd !== 128'h0000123C_00001238_00001234_00001230) begin
      n_fail++; $display("FAIL pattern_data got=%h want=0000123c000012380000123400001230", rd);
    end
    $display("read 0x1234: lat=%0d rdata=%h", lat, rd);
  endtask

  task automatic test_write_read();
    logic [127:0] rd, wd, exp; int lat; bit to;
    wd = {4{32'hDEADBEEF}};
    transact(1'b1, 32'h40, wd, 1'b1, 0, rd, lat, to);
    n_checks++;
    if (to || lat != 3) begin n_fail++; $display("FAIL write_ack_latency got=%0d to=%0b want=3", lat, to); end
    n_checks++;
    if (rd !== wd) begin n_fail++; $display("FAIL write_ack_data got=%h want=%h", rd, wd); end
    $display("write 0x40: ack rdata=%h", rd);
    transact(1'b0, 32'h44, '0, 1'b1, 1, rd, lat, to);
    n_checks++;
    if (to || rd !== wd) begin n_fail++; $display("FAIL read_written got=%h want=%h", rd, wd); end
    $display("read 0x44: rdata=%h", rd);
    exp = 128'h0000005C_00000058_00000054_00000050;
    transact(1'b0, 32'h50, '0, 1'b1, 0, rd, lat, to);
    n_checks++;
    if (to || rd !== exp) begin n_fail++; $display("FAIL read_unwritten got=%h want=%h", rd, exp); end
    $display("read 0x50: rdata=%h", rd);
  endtask

  task automatic test_stall();
    logic [127:0] rd, exp; int lat; bit to; logic [31:0] a;
    a = {22'h0, 6'($urandom_range(0, 63)), 4'($urandom_range(0, 15))};
    if (a[9:4] == 6'd8) a[9:4] = 6'd9;   // keep away from the rejected write's line
    exp = model_line(a);
    transact(1'b0, a, '0, 1'b0, 0, rd, lat, to);
    n_checks++;
    if (to || rd !== exp) begin n_fail++; $display("FAIL stall_first_data got=%h want=%h", rd, exp); end
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h80; req_wdata = {4{32'hA5A5_5A5A}}; end
      if (c == 3) req_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid c=%0d got=%b want=1", c, resp_valid); end
      n_checks++;
      if (resp_rdata !== exp) begin n_fail++; $display("FAIL stall_data c=%0d got=%h want=%h", c, resp_rdata, exp); end
      n_checks++;
      if (req_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready c=%0d got=%b want=0", c, req_ready); end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 128'h0) begin
      n_fail++; $display("FAIL stall_release got=%b/%h want=0/0", resp_valid, resp_rdata);
    end
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready_after got=%b want=1", req_ready); end
    exp = model_line(32'h80);
    transact(1'b0, 32'h80, '0, 1'b1, 0, rd, lat, to);
    n_checks++;
    if (to || rd !== exp) begin n_fail++; $display("FAIL stall_ignored_write got=%h want=%h", rd, exp); end
    $display("stall read 0x%h: held 5 cycles, rdata=%h; 0x80 after=%h", a, exp, rd);
  endtask

  task automatic test_alias();
    logic [127:0] rd, wd; int lat; bit to;
    wd = {$urandom, $urandom, $urandom, $urandom};
    transact(1'b1, 32'h40, wd, 1'b1, 0, rd, lat, to);
    transact(1'b0, 32'h440, '0, 1'b1, 0, rd, lat, to);
    n_checks++;
    if (to || rd !== wd) begin n_fail++; $display("FAIL alias_data got=%h want=%h", rd, wd); end
    $display("alias read 0x440: rdata=%h", rd);
  endtask

  task automatic test_reset_mid();
    logic [127:0] rd, exp; int lat; bit to; int n;
    bit seen;
    transact(1'b1, 32'h40, {4{32'h1357_9BDF}}, 1'b1, 0, rd, lat, to);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);                      // now in WAIT
    seen = resp_valid;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 128'h0) begin
      n_fail++; $display("FAIL midreset_outputs got=%b/%b/%h want=0/0/0", req_ready, resp_valid, resp_rdata);
    end
    repeat (2) begin @(negedge clk); seen = seen | resp_valid; end
    rst_n = 1'b1;
    model_clear();
    repeat (4) begin @(negedge clk); seen = seen | resp_valid; end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL midreset_no_resp got=resp_valid seen want=none"); end
    exp = 128'h0000004C_00000048_00000044_00000040;
    transact(1'b0, 32'h40, '0, 1'b1, 0, rd, lat, to);
    n_checks++;
    if (to || rd !== exp) begin n_fail++; $display("FAIL midreset_invisible got=%h want=%h", rd, exp); end
    $display("reset mid-read: read 0x40 after=%h", rd);
  endtask

  task automatic test_random();
    logic [127:0] rd, wd, exp; int lat; bit to; logic [31:0] a; logic we;
    for (int t = 0; t < 40; t++) begin
      a  = 32'($urandom_range(0, 32'h7FF));
      we = 1'($urandom_range(0, 1));
      wd = {$urandom, $urandom, $urandom, $urandom};
      exp = we ? wd : model_line(a);
      transact(we, a, wd, 1'b1, $urandom_range(0, 3), rd, lat, to);
      n_checks++;
      if (to || lat != 3) begin n_fail++; $display("FAIL rand_latency t=%0d got=%0d want=3", t, lat); end
      n_checks++;
      if (rd !== exp) begin n_fail++; $display("FAIL rand_data t=%0d got=%h want=%h", t, rd, exp); end
      $display("rand t=%0d we=%0b addr=%h rdata=%h", t, we, a, rd);
    end
  endtask

  task automatic test_back_to_back();
    int acc_at [2];
    int resp_at [2];
    logic [127:0] resp_d [2];
    logic [31:0] addrs [2];
    logic [127:0] exp;
    int nacc, nresp;
    addrs[0] = 32'h0; addrs[1] = 32'h10;
    nacc = 0; nresp = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (resp_valid_1 && nresp < 2) begin resp_at[nresp] = n; resp_d[nresp] = resp_rdata_1; nresp++; end
      if (nacc < 2) begin
        req_addr_1 = addrs[nacc];
        req_valid_1 = 1'b1;
        if (req_ready_1) begin acc_at[nacc] = n; nacc++; end
      end else begin
        req_valid_1 = 1'b0;
      end
    end
    req_valid_1 = 1'b0;
    n_checks++;
    if (nacc != 2 || nresp != 2) begin
      n_fail++; $display("FAIL b2b_counts got=%0d/%0d want=2/2", nacc, nresp);
    end else begin
      n_checks++;
      if (acc_at[1] - acc_at[0] != 2) begin n_fail++; $display("FAIL b2b_accept_gap got=%0d want=2", acc_at[1] - acc_at[0]); end
      for (int i = 0; i < 2; i++) begin
        exp = {addrs[i] + 32'd12, addrs[i] + 32'd8, addrs[i] + 32'd4, addrs[i]};
        n_checks++;
        if (resp_at[i] != acc_at[i] + 1) begin n_fail++; $display("FAIL b2b_latency i=%0d got=%0d want=1", i, resp_at[i] - acc_at[i]); end
        n_checks++;
        if (resp_d[i] !== exp) begin n_fail++; $display("FAIL b2b_data i=%0d got=%h want=%h", i, resp_d[i], exp); end
        $display("b2b i=%0d accept=%0d resp=%0d rdata=%h", i, acc_at[i], resp_at[i], resp_d[i]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    req_valid_1 = 1'b0; req_we_1 = 1'b0; req_addr_1 = '0; req_wdata_1 = '0; resp_ready_1 = 1'b1;
    model_clear();
    test_reset();
    test_read_pattern();
    test_write_read();
    test_stall();
    test_alias();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/main_memory_line_ctrl.md
MAIN_MEMORY_LINE_CTRL -- requirements
Module: main_memory_line_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter WORD_W, default 32, word width in bits.
REQ-003 SHALL have parameter WORDS, default 4, words per line; LINE_W = WORDS*WORD_W (default 128).
REQ-004 SHALL have parameter DEPTH, default 64, number of stored lines (power of 2).
REQ-005 SHALL have parameter LATENCY, default 3, accept-to-response cycles (>=1).
REQ-006 SHALL have one clock and an asynchronous active-low reset.
REQ-007 SHALL have ports:
  - clk  in  1  rising-edge clock.
  - rst_n  in  1  async active-low reset.
  - req_valid  in  1  request present.
  - req_ready  out  1  request accepted when both high.
  - req_we  in  1  1 = line write, 0 = line read.
  - req_addr  in  ADDR_W  byte address; low offset bits ignored.
  - req_wdata  in  LINE_W  write line, word 0 in bits [WORD_W-1:0].
  - resp_valid  out  1  response present.
  - resp_ready  in  1  response consumed when both high.
  - resp_rdata  out  LINE_W  read line, or written line for a write ack.

Function
REQ-008 SHALL use OFF = log2(WORDS*WORD_W/8) and IDX = log2(DEPTH); aligned address = req_addr with bits [OFF-1:0] cleared; line index = req_addr[OFF+IDX-1:OFF]; upper bits unchecked, so aliasing is intended.
REQ-009 SHALL keep one valid bit per line; an unwritten line returns the default pattern: word k = aligned address + k*(WORD_W/8), truncated to WORD_W.
REQ-010 SHALL return the stored line for reads of a line whose valid bit is set.
REQ-011 SHALL commit a write (data and valid bit) on the accepting clock edge.
REQ-012 SHALL capture the read line at the accepting edge; resp_rdata SHALL NOT change while resp_valid is high.
REQ-013 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE.
  - req_ready = 1 only in IDLE.
  - Accept at edge T moves to WAIT, or directly to RESP when LATENCY = 1.
  - resp_valid SHALL first be high in the cycle following edge T+LATENCY-1, i.e. LATENCY cycles after accept.
REQ-014 SHALL count WAIT cycles with a down-counter of width clog2(LATENCY)+1.
REQ-015 SHALL hold resp_valid high in RESP until resp_ready is high, then go to IDLE on that edge.
REQ-016 SHALL allow one outstanding request only; req_valid outside IDLE is ignored and not queued.
REQ-017 SHALL acknowledge writes like reads, with resp_rdata = the written line.
REQ-018 SHALL drive resp_rdata = 0 whenever resp_valid is low.

Reset
REQ-019 SHALL, while rst_n is low, force state IDLE, counter 0, resp_valid 0, resp_rdata 0, req_ready 0, and clear all valid bits.
REQ-020 SHALL raise req_ready in the first cycle after rst_n deasserts.
REQ-021 SHALL, on reset mid-operation, abort with no response; earlier writes become invisible because their valid bits are cleared. Line storage itself is not reset.

Structure
REQ-022 SHALL place the FSM state enum, default parameter values and the pattern-line function in package main_memory_pkg.
REQ-023 SHALL instantiate one sub-module, mem_line_store, holding the DEPTH x LINE_W array, the valid bits, and the pattern fallback.

Verification
REQ-024 Reset, then read 0x0000_1234 with LATENCY = 3 -> resp_valid exactly 3 cycles after accept; rdata words 0..3 = 0x1230, 0x1234, 0x1238, 0x123C.
REQ-025 Write 0x40 with all words = 0xDEADBEEF, then read 0x44 -> ack, then 4 x 0xDEADBEEF; read 0x50 -> 0x50, 0x54, 0x58, 0x5C.
REQ-026 Hold resp_ready low 5 cycles -> resp_valid and rdata stable and req_ready = 0; a req_valid pulse in that window is not accepted.
REQ-027 Write 0x40, then assert rst_n low during WAIT of a read -> no resp_valid; after reset, read 0x40 -> 0x40, 0x44, 0x48, 0x4C.
REQ-028 Write 0x40, then read 0x440 (DEPTH = 64, both index 4) -> written data returned.
REQ-029 LATENCY = 1, resp_ready tied high, back-to-back reads 0x0 and 0x10 -> each resp one cycle after its accept; accepts two cycles apart.
